// File: rtl/router_pkg.sv
// Shared constants and helpers for the sync router slice.
package router_pkg;

  localparam int DEF_NUM_CH  = 3;
  localparam int DEF_ADDR_W  = 2;
  localparam int DEF_TIMEOUT = 30;
  localparam int MAX_CH      = 8;

  function automatic logic [MAX_CH-1:0] onehot(
    input logic [2:0] idx
  );
    logic [MAX_CH-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/router_sync_mc_if.sv
// Router synchroniser bus: header/write control, FIFO status,
// per-channel valid/read and timeout signals.
interface router_sync_mc_if
  import router_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              detect_add;
  logic [ADDR_W-1:0] data_in;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] read_enb;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] soft_reset;
  logic              addr_err;

  modport master (
    output detect_add, data_in, write_enb_reg,
    output read_enb, full, empty,
    input  write_enb, fifo_full, vld_out,
    input  soft_reset, addr_err
  );

  modport slave (
    input  detect_add, data_in, write_enb_reg,
    input  read_enb, full, empty,
    output write_enb, fifo_full, vld_out,
    output soft_reset, addr_err
  );

endinterface

// File: rtl/router_sync_timer.sv
// Per-channel unread-data watchdog; pulses soft_reset
// after TIMEOUT consecutive valid-but-unread cycles.
module router_sync_timer #(
  parameter int TIMEOUT = 30
) (
  input  logic clock,
  input  logic reset,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else begin
      soft_reset <= 1'b0;
      if (!vld || rd) begin
        cnt <= '0;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        cnt        <= '0;
        soft_reset <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_sync_mc.sv
// Router synchroniser: destination latch, write steering, timeouts.
// ROUTER_SYNC_SRST_CNT_EN adds per-channel soft_reset counters.
module router_sync_mc
  import router_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic             clock,
  input logic             reset,
  router_sync_mc_if.slave bus
`ifdef ROUTER_SYNC_SRST_CNT_EN
  ,
  output logic [NUM_CH*8-1:0] srst_cnt
`endif
);

  logic [ADDR_W-1:0] dest;
  logic [NUM_CH-1:0] sel;

  always_ff @(posedge clock) begin
    if (reset) begin
      dest <= '0;
    end else if (bus.detect_add) begin
      dest <= bus.data_in;
    end
  end

  // out-of-range dest may alias in the decode; addr_err masks it
  assign sel = NUM_CH'(onehot(3'(dest)));

  assign bus.addr_err  = (int'(dest) >= NUM_CH);
  assign bus.write_enb = (bus.write_enb_reg && !bus.addr_err)
                       ? sel : '0;
  assign bus.fifo_full = !bus.addr_err && |(bus.full & sel);
  assign bus.vld_out   = ~bus.empty;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    router_sync_timer #(
      .TIMEOUT(TIMEOUT)
    ) u_timer (
      .clock     (clock),
      .reset     (reset),
      .vld       (bus.vld_out[i]),
      .rd        (bus.read_enb[i]),
      .soft_reset(bus.soft_reset[i])
    );

`ifdef ROUTER_SYNC_SRST_CNT_EN
    logic [7:0] pulses;

    always_ff @(posedge clock) begin
      if (reset) begin
        pulses <= '0;
      end else if (bus.soft_reset[i] && pulses != 8'hFF) begin
        pulses <= pulses + 1'b1;
      end
    end

    assign srst_cnt[i*8 +: 8] = pulses;
`endif
  end

endmodule

// File: doc/router_sync_mc.md
ROUTER_SYNC_MC -- requirements
Module: router_sync_mc

Interface
REQ-001 Parameter NUM_CH, default 3: number of output channels/FIFOs, legal range 2..8.
REQ-002 Parameter ADDR_W, default 2: width of destination address field, SHALL satisfy 2**ADDR_W >= NUM_CH.
REQ-003 Parameter TIMEOUT, default 30: unread-valid cycles before channel soft reset, legal range 2..255.
REQ-004 clock  in  1  sole clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 detect_add  in  1  header cycle strobe, latch data_in as destination.
REQ-007 data_in  in  ADDR_W  destination address from packet header.
REQ-008 write_enb_reg  in  1  FSM request to write current byte.
REQ-009 read_enb  in  NUM_CH  per-channel read strobe from consumer.
REQ-010 full  in  NUM_CH  per-channel FIFO full.
REQ-011 empty  in  NUM_CH  per-channel FIFO empty.
REQ-012 write_enb  out  NUM_CH  one-hot FIFO write enable.
REQ-013 fifo_full  out  1  full flag of selected channel.
REQ-014 vld_out  out  NUM_CH  per-channel data-valid.
REQ-015 soft_reset  out  NUM_CH  per-channel one-cycle timeout pulse.
REQ-016 addr_err  out  1  latched destination is out of range.

Function
REQ-017 dest register SHALL load data_in on a clock edge with detect_add=1, otherwise hold.
REQ-018 addr_err SHALL be combinationally 1 when dest >= NUM_CH, else 0.
REQ-019 write_enb SHALL equal one-hot(dest) when write_enb_reg=1 and addr_err=0, else all zeros; never more than one bit set.
REQ-020 fifo_full SHALL equal full[dest] when addr_err=0, else 0; purely combinational, zero latency.
REQ-021 vld_out[i] SHALL equal ~empty[i], combinational.
REQ-022 Per-channel counter cnt[i], width clog2(TIMEOUT+1): cleared to 0 on any edge where vld_out[i]=0 or read_enb[i]=1.
REQ-023 Otherwise cnt[i] SHALL increment; on the edge where cnt[i]==TIMEOUT-1 it SHALL wrap to 0 and soft_reset[i] SHALL be 1 for the following cycle.
REQ-024 soft_reset[i] therefore rises on the edge ending the TIMEOUT-th consecutive cycle with vld_out[i]=1 and read_enb[i]=0; it repeats every TIMEOUT cycles while that condition persists.
REQ-025 read_enb[i]=1 in the same cycle the counter would reach TIMEOUT SHALL take priority: no pulse, cnt cleared.
REQ-026 Channels SHALL be fully independent; simultaneous pulses on several channels are legal.
REQ-027 detect_add and write_enb_reg both high in one cycle: write_enb uses the old dest that cycle, new dest from the next cycle.

Reset
REQ-028 While reset=1: dest=0, all cnt=0, soft_reset=0; write_enb/fifo_full/addr_err follow dest=0 combinationally.
REQ-029 Reset asserted mid-count SHALL abort any pending timeout; no soft_reset pulse within TIMEOUT cycles after release.

Configuration
REQ-030 Macro ROUTER_SYNC_SRST_CNT_EN defined: adds output srst_cnt (NUM_CH*8 bits), per-channel 8-bit counter of soft_reset pulses, saturating at 255, cleared by reset.
REQ-031 Macro undefined: port srst_cnt and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-032 Shared package router_pkg SHALL hold DEF_NUM_CH, DEF_ADDR_W, DEF_TIMEOUT constants and a one-hot decode function.
REQ-033 Per-channel counter/pulse logic SHALL be sub-module router_sync_timer (params TIMEOUT; ports clock, reset, vld, rd, soft_reset), instantiated NUM_CH times by generate.

Verification (NUM_CH=3, TIMEOUT=30 unless stated)
REQ-034 detect_add with data_in=2, then write_enb_reg=1 -> write_enb=3'b100; full=3'b100 -> fifo_full=1.
REQ-035 data_in=3 latched -> addr_err=1, write_enb=0 with write_enb_reg=1, fifo_full=0 with full=3'b111.
REQ-036 empty[0]=0, read_enb[0]=0 held 65 cycles -> soft_reset[0] single-cycle pulses after cycles 30 and 60 only.
REQ-037 Same, read_enb[0]=1 in cycle 30 -> no pulse; pulse next after 30 further unread cycles.
REQ-038 Reset asserted at cycle 20 of a count, released -> soft_reset[0]=0 for 29 cycles, pulse after cycle 30.
REQ-039 ROUTER_SYNC_SRST_CNT_EN defined, channel 1 stalled 300*30 cycles -> srst_cnt[15:8] saturates at 255.
